muldiv_ctrl: RTL and testbench

// Execute-stage initiator for the iterative HI/LO multiply/divide unit. Decodes MIPS

---
 rtl/muldiv_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Execute-stage initiator for an iterative HI/LO multiply/divide unit.
// Decodes MIPS R-type funct codes (MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU).
// Drives the unit's en/op/operand interface and follows the unit's busy flag.
// MULT/DIV issue without blocking the pipeline. Any later HI/LO access stalls
// until the unit has finished.
//
// Ports
//   i_clk           clock
//   i_rst           synchronous reset, active-high
//   i_valid         decoded instruction valid this cycle
//   i_funct         MIPS R-type funct field
//   i_rs_data       rs operand
//   i_rt_data       rt operand
//   i_flush         pipeline flush, drops the current request
//   o_stall         hold the instruction (inputs stay stable while high)
//   o_result        MFHI/MFLO data (pass-through of i_md_dout)
//   o_result_valid  o_result valid this cycle
//   o_div_zero_exc  one-cycle divide-by-zero trap pulse
//   o_md_err        sticky: unit never went busy, or stayed busy too long
//   o_md_en         unit enable
//   o_md_op         unit op: 100 MULT, 101 MULTU, 110 DIV, 111 DIVU,
//                            000 rd HI, 010 rd LO, 001 wr HI, 011 wr LO
//   o_md_a/o_md_b   unit operands (rs/rt)
//   o_md_arst_n     unit async reset, registered ~i_rst
//   i_md_busy       unit busy, rises the cycle after an issue
//   i_md_div_zero   unit flag: DIV/DIVU presented with b == 0
//   i_md_dout       unit HI/LO read data, selected by o_md_op[1]
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 128,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [5:0]            i_funct,
   input  logic [DATA_WIDTH-1:0] i_rs_data,
   input  logic [DATA_WIDTH-1:0] i_rt_data,
   input  logic                  i_flush,
   output logic                  o_stall,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_result_valid,
   output logic                  o_div_zero_exc,
   output logic                  o_md_err,
   output logic                  o_md_en,
   output logic [2:0]            o_md_op,
   output logic [DATA_WIDTH-1:0] o_md_a,
   output logic [DATA_WIDTH-1:0] o_md_b,
   output logic                  o_md_arst_n,
   input  logic                  i_md_busy,
   input  logic                  i_md_div_zero,
   input  logic [DATA_WIDTH-1:0] i_md_dout
);

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   localparam logic [2:0] OP_RD_HI = 3'b000;
   localparam logic [2:0] OP_WR_HI = 3'b001;
   localparam logic [2:0] OP_RD_LO = 3'b010;
   localparam logic [2:0] OP_WR_LO = 3'b011;
   localparam logic [2:0] OP_MULT  = 3'b100;
   localparam logic [2:0] OP_MULTU = 3'b101;
   localparam logic [2:0] OP_DIV   = 3'b110;
   localparam logic [2:0] OP_DIVU  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_RUN
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 err_set;
   logic                 exc_nxt;

   logic                 is_mf, is_mt, is_arith, is_div;
   logic [2:0]           op_dec;
   logic                 md_req;

   // Operands and read data are plain pass-throughs; the unit selects HI/LO
   // from o_md_op[1], so o_result is correct in the same cycle as MF*.
   assign o_md_a   = i_rs_data;
   assign o_md_b   = i_rt_data;
   assign o_result = i_md_dout;

   // Funct decode.
   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      is_mf    = 1'b0;
      is_mt    = 1'b0;
      is_arith = 1'b0;
      is_div   = 1'b0;
      op_dec   = OP_RD_HI;
      case (i_funct)
         F_MFHI:  begin is_mf = 1'b1; op_dec = OP_RD_HI; end
         F_MFLO:  begin is_mf = 1'b1; op_dec = OP_RD_LO; end
         F_MTHI:  begin is_mt = 1'b1; op_dec = OP_WR_HI; end
         F_MTLO:  begin is_mt = 1'b1; op_dec = OP_WR_LO; end
         F_MULT:  begin is_arith = 1'b1; op_dec = OP_MULT;  end
         F_MULTU: begin is_arith = 1'b1; op_dec = OP_MULTU; end
         F_DIV:   begin is_arith = 1'b1; is_div = 1'b1; op_dec = OP_DIV;  end
         F_DIVU:  begin is_arith = 1'b1; is_div = 1'b1; op_dec = OP_DIVU; end
         default: ;
      endcase
   end

   // A request that may touch the unit this cycle. Flush and reset both
   // suppress it, which zeroes every combinational output below.
   assign md_req = i_valid & ~i_flush & ~i_rst & (is_mf | is_mt | is_arith);

   // Next-state and output logic.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      err_set        = 1'b0;
      o_stall        = 1'b0;
      o_md_en        = 1'b0;
      o_result_valid = 1'b0;
      // op stays decoded even while stalled, keeping the read select valid.
      o_md_op        = md_req ? op_dec : OP_RD_HI;

      case (state)
         S_IDLE: begin
            if (md_req) begin
               if (is_mf) o_result_valid = 1'b1;
               else       o_md_en        = 1'b1;
               // A divide by zero is refused by the unit: it never goes busy.
               if (is_arith && !(is_div && i_md_div_zero)) state_nxt = S_START;
            end
         end

         S_START: begin
            o_stall = md_req;
            if (i_md_busy) begin
               state_nxt = S_RUN;
            end else begin
               err_set   = 1'b1;
               state_nxt = S_IDLE;
            end
         end

         S_RUN: begin
            o_stall = md_req;
            if (!i_md_busy) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
               err_set   = 1'b1;
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // The trap is suppressed for one cycle after a pulse so it can never stay
   // high two cycles in a row.
   assign exc_nxt = o_md_en & is_div & i_md_div_zero & ~o_div_zero_exc;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      // Delayed one cycle so the unit is cleared after the controller is idle.
      o_md_arst_n <= ~i_rst;
      if (i_rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         o_div_zero_exc <= 1'b0;
         o_md_err       <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         o_div_zero_exc <= exc_nxt;
         if (err_set) o_md_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Bench for muldiv_ctrl. A small behavioural HI/LO unit sits on the md_*
// interface. It has a fixed latency and can be made to stick busy or never
// go busy. Expected MFHI/MFLO data is queued when an MF* is driven. It is
// popped and compared whenever the controller flags o_result_valid.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 20;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic [5:0]  i_funct;
   logic [31:0] i_rs_data;
   logic [31:0] i_rt_data;
   logic        i_flush;
   logic        o_stall;
   logic [31:0] o_result;
   logic        o_result_valid;
   logic        o_div_zero_exc;
   logic        o_md_err;
   logic        o_md_en;
   logic [2:0]  o_md_op;
   logic [31:0] o_md_a;
   logic [31:0] o_md_b;
   logic        o_md_arst_n;
   logic        i_md_busy;
   logic        i_md_div_zero;
   logic [31:0] i_md_dout;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   muldiv_ctrl #(.DATA_WIDTH(32), .TIMEOUT(128), .CNT_WIDTH(8)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_valid        (i_valid),
      .i_funct        (i_funct),
      .i_rs_data      (i_rs_data),
      .i_rt_data      (i_rt_data),
      .i_flush        (i_flush),
      .o_stall        (o_stall),
      .o_result       (o_result),
      .o_result_valid (o_result_valid),
      .o_div_zero_exc (o_div_zero_exc),
      .o_md_err       (o_md_err),
      .o_md_en        (o_md_en),
      .o_md_op        (o_md_op),
      .o_md_a         (o_md_a),
      .o_md_b         (o_md_b),
      .o_md_arst_n    (o_md_arst_n),
      .i_md_busy      (i_md_busy),
      .i_md_div_zero  (i_md_div_zero),
      .i_md_dout      (i_md_dout)
   );

   always #5 i_clk = ~i_clk;

   // ---------------- behavioural HI/LO unit ----------------
   logic [31:0] u_hi, u_lo, p_hi, p_lo;
   logic        u_busy;
   int          u_cnt;
   bit          stuck = 1'b0;
   bit          never = 1'b0;

   function automatic logic [63:0] unit_calc(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint sp;
      logic [63:0] up;
      logic [31:0] q, r;
      case (op)
         3'b100: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
         3'b101: begin up = {32'd0, a} * {32'd0, b}; return up; end
         3'b110: begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         default: begin q = a / b; r = a % b; return {r, q}; end
      endcase
   endfunction

   assign i_md_busy     = u_busy;
   assign i_md_div_zero = o_md_en & o_md_op[2] & o_md_op[1] & (o_md_b == 32'd0);
   assign i_md_dout     = o_md_op[1] ? u_lo : u_hi;

   always @(posedge i_clk or negedge o_md_arst_n) begin
      if (!o_md_arst_n) begin
         u_hi <= '0; u_lo <= '0; p_hi <= '0; p_lo <= '0;
         u_busy <= 1'b0; u_cnt <= 0;
      end else if (u_busy) begin
         if (u_cnt <= 1 && !stuck) begin
            u_busy <= 1'b0;
            u_hi   <= p_hi;
            u_lo   <= p_lo;
         end else if (u_cnt > 1) begin
            u_cnt <= u_cnt - 1;
         end
      end else if (o_md_en) begin
         if (o_md_op == 3'b001) u_hi <= o_md_a;
         else if (o_md_op == 3'b011) u_lo <= o_md_a;
         else if (o_md_op[2] && !i_md_div_zero && !never) begin
            {p_hi, p_lo} <= unit_calc(o_md_op, o_md_a, o_md_b);
            u_busy <= 1'b1;
            u_cnt  <= o_md_op[1] ? DIV_LAT : MUL_LAT;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every MF* completion pops one expected value.
   always @(negedge i_clk) begin
      if (o_result_valid === 1'b1) begin
         if (sb_q.size() == 0) check("sb_unexpected_result", o_result_valid, 1'b0);
         else                  check("mf_data", o_result, sb_q.pop_front());
      end
   end

   // Drive one instruction and hold it until the controller accepts it.
   // Entered and left one time unit after a rising edge.
   task automatic do_instr(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                           output int stalls, output logic en, output logic [2:0] op);
      bit done = 1'b0;
      i_valid = 1'b1; i_funct = f; i_rs_data = rs; i_rt_data = rt;
      stalls = 0; en = 1'b0; op = 3'b000;
      for (int k = 0; k < 400; k++) begin
         @(negedge i_clk);
         if (!o_stall) begin
            en = o_md_en; op = o_md_op; done = 1'b1;
            break;
         end
         stalls++;
         @(posedge i_clk); #1;
      end
      if (!done) check("stall_timeout", 32'd0, 32'd1);
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_funct = '0;
   endtask

   task automatic rst_pulse();
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      @(posedge i_clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         st;
      logic       en;
      logic [2:0] op;
      int         n;

      i_rst = 1'b1; i_valid = 1'b1; i_funct = F_MFLO;
      i_rs_data = '0; i_rt_data = '0; i_flush = 1'b0;

      // Reset state: comb outputs forced low even with a valid MFLO present.
      @(posedge i_clk); #1;
      @(negedge i_clk);
      check("rst_stall",   o_stall,        1'b0);
      check("rst_rvalid",  o_result_valid, 1'b0);
      check("rst_en",      o_md_en,        1'b0);
      check("rst_op",      o_md_op,        3'b000);
      check("rst_err",     o_md_err,       1'b0);
      check("rst_exc",     o_div_zero_exc, 1'b0);
      check("rst_arst_n",  o_md_arst_n,    1'b0);
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_funct = '0; i_rst = 1'b0;
      @(posedge i_clk); #1;
      @(negedge i_clk);
      check("arst_n_release", o_md_arst_n, 1'b1);
      @(posedge i_clk); #1;

      // MULT 7 * -3, then MFLO stalls until busy falls, then MFHI free.
      do_instr(F_MULT, 32'd7, 32'hFFFF_FFFD, st, en, op);
      check("mult_stall", st, 0);
      check("mult_en",    en, 1'b1);
      check("mult_op",    op, 3'b100);
      sb_q.push_back(32'hFFFF_FFEB);
      do_instr(F_MFLO, '0, '0, st, en, op);
      check("mflo_wait", st, MUL_LAT + 1);
      check("mflo_op",   op, 3'b010);
      sb_q.push_back(32'hFFFF_FFFF);
      do_instr(F_MFHI, '0, '0, st, en, op);
      check("mfhi_stall", st, 0);
      check("mfhi_en",    en, 1'b0);
      check("mfhi_op",    op, 3'b000);

      // DIVU 100 / 7: HI = 2, LO = 14.
      do_instr(F_DIVU, 32'd100, 32'd7, st, en, op);
      check("divu_op", op, 3'b111);
      sb_q.push_back(32'd2);
      do_instr(F_MFHI, '0, '0, st, en, op);
      check("divu_mfhi_wait", st, DIV_LAT + 1);
      sb_q.push_back(32'd14);
      do_instr(F_MFLO, '0, '0, st, en, op);
      check("divu_mflo_stall", st, 0);

      // DIV by zero: issued, trap one cycle later only, HI untouched.
      do_instr(F_DIV, 32'd5, 32'd0, st, en, op);
      check("div0_stall", st, 0);
      check("div0_en",    en, 1'b1);
      check("div0_op",    op, 3'b110);
      @(negedge i_clk);
      check("div0_exc_n1", o_div_zero_exc, 1'b1);
      @(posedge i_clk); #1;
      sb_q.push_back(32'd2);
      do_instr(F_MFHI, '0, '0, st, en, op);
      check("div0_mfhi_stall", st, 0);
      @(negedge i_clk);
      check("div0_exc_later", o_div_zero_exc, 1'b0);
      @(posedge i_clk); #1;

      // MTLO then MFLO back to back.
      do_instr(F_MTLO, 32'h1234, '0, st, en, op);
      check("mtlo_en", en, 1'b1);
      check("mtlo_op", op, 3'b011);
      sb_q.push_back(32'h1234);
      do_instr(F_MFLO, '0, '0, st, en, op);
      check("mtlo_mflo_stall", st, 0);

      // Flush a stalled MFLO; the divide keeps running.
      do_instr(F_DIVU, 32'd50, 32'd5, st, en, op);
      i_valid = 1'b1; i_funct = F_MFLO;
      @(negedge i_clk);
      check("flush_pre_stall", o_stall, 1'b1);
      @(posedge i_clk); #1;
      i_flush = 1'b1;
      @(negedge i_clk);
      check("flush_stall",  o_stall,        1'b0);
      check("flush_rvalid", o_result_valid, 1'b0);
      check("flush_en",     o_md_en,        1'b0);
      @(posedge i_clk); #1;
      i_flush = 1'b0; i_valid = 1'b0; i_funct = '0;
      repeat (30) @(posedge i_clk);
      #1;
      sb_q.push_back(32'd10);
      do_instr(F_MFLO, '0, '0, st, en, op);
      check("flush_after_stall", st, 0);

      // Reset while RUN with an MFLO pending; unit cleared a cycle later.
      do_instr(F_DIVU, 32'd9, 32'd2, st, en, op);
      sb_q.push_back(32'd0);
      i_valid = 1'b1; i_funct = F_MFLO;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         check("midrst_pre_stall", o_stall, 1'b1);
         @(posedge i_clk); #1;
      end
      i_rst = 1'b1;
      @(negedge i_clk);
      check("midrst_stall_in_rst", o_stall, 1'b0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      check("midrst_stall_after", o_stall,        1'b0);
      check("midrst_rvalid",      o_result_valid, 1'b1);
      check("midrst_arst_n_low",  o_md_arst_n,    1'b0);
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_funct = '0;
      @(negedge i_clk);
      check("midrst_arst_n_high", o_md_arst_n, 1'b1);
      @(posedge i_clk); #1;

      // Busy stuck high: error after 128 RUN cycles.
      stuck = 1'b1;
      do_instr(F_MULT, 32'd1, 32'd1, st, en, op);
      n = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge i_clk);
         n++;
         if (o_md_err) break;
      end
      check("timeout_cycles", n, 130);
      check("timeout_err",    o_md_err, 1'b1);
      @(posedge i_clk); #1;
      stuck = 1'b0;
      rst_pulse();
      @(negedge i_clk);
      check("err_cleared", o_md_err, 1'b0);
      @(posedge i_clk); #1;

      // Busy never rises: error raised out of START.
      never = 1'b1;
      do_instr(F_MULT, 32'd3, 32'd4, st, en, op);
      @(negedge i_clk);
      check("nobusy_err_start", o_md_err, 1'b0);
      @(negedge i_clk);
      check("nobusy_err", o_md_err, 1'b1);
      @(posedge i_clk); #1;
      never = 1'b0;
      sb_q.push_back(32'd0);
      do_instr(F_MFHI, '0, '0, st, en, op);
      check("nobusy_mfhi_stall", st, 0);

      repeat (2) @(posedge i_clk);
      check("sb_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
